rank_classifier: RTL and testbench
==================================

# rank_classifier

Collects the per-template XOR mismatch scores produced by the bank of rank-template matchers, one matcher per card rank. Once every matcher has reported for the current card corner, it selects the template with the lowest mismatch count and reports the winning rank index with a one-cycle valid pulse. A threshold test and a timeout guard the result. The block sits directly downstream of the matcher bank and upstream of game-state logic.

## Interface
- NUM_TEMPLATES, 13: number of matchers/ranks; index i corresponds to rank i (0 = A … 12 = K).
- SCORE_WIDTH, 11: score width, equal to $clog2(corner_width*rank_height) for a 28x40 corner.
- MATCH_THRESHOLD, 400: best score strictly greater than this yields no_match.
- TIMEOUT_CYCLES, 4096: maximum cycles from first score to all scores in COLLECT.
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- score_in  input  NUM_TEMPLATES*SCORE_WIDTH  flattened scores; matcher i occupies bits [i*SCORE_WIDTH +: SCORE_WIDTH].
- score_valid  input  NUM_TEMPLATES  one-cycle pulse per matcher when its score is final.
- rank_out  output  $clog2(NUM_TEMPLATES)  winning template index.
- rank_score  output  SCORE_WIDTH  mismatch count of the winner.
- rank_valid  output  1  one-cycle pulse; rank_out, rank_score, no_match and timeout are valid in that cycle.
- no_match  output  1  best score exceeds MATCH_THRESHOLD, or the result was produced by timeout.
- timeout  output  1  result was forced by the timeout.
- overrun  output  1  sticky; set if a score_valid arrives in COMPARE or REPORT; cleared only by rst.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, COLLECT, COMPARE, REPORT.
- IDLE: on any score_valid bit, latch the matching score(s) into the score register file and set their seen bits.
  - Go to COMPARE if all seen bits are now set; otherwise go to COLLECT.
  - Clear the timeout counter on entry to COLLECT.
- COLLECT: latch each score_valid[i] into slot i and set seen[i]; the timeout counter increments every cycle.
  - A repeated valid for an already-seen index overwrites the slot with the new score.
  - Go to COMPARE when all seen bits are set, including the seen bits being set in the current cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 before that, set the timeout flag and go to COMPARE.
- COMPARE: scan index 0..NUM_TEMPLATES-1, one index per cycle.
  - Only seen slots are candidates.
  - Replace the running best only on strictly lower score, so ties resolve to the lowest index.
  - Initialise the running best to all-ones score and index 0.
  - After the last index, go to REPORT.
- REPORT: drive rank_out and rank_score from the running best and pulse rank_valid.
  - no_match = timeout_flag OR (best > MATCH_THRESHOLD).
  - If no slot was seen, rank_score = all-ones and no_match = 1.
  - Next state is IDLE; seen bits, timeout flag and counter clear on that transition.
- Arithmetic: the comparison is unsigned at SCORE_WIDTH. There are no adders other than the scan index and the timeout counter. The scan index width is $clog2(NUM_TEMPLATES).
- score_valid in COMPARE or REPORT: the score is discarded and overrun is set. A card corner in progress is never corrupted.

## Timing
- Reset values: rank_out 0, rank_score 0, rank_valid 0, no_match 0, timeout 0, overrun 0, busy 0. State IDLE, all seen bits 0.
- rank_out, rank_score, no_match and timeout hold their last reported value until the next REPORT.
- Let the last required score_valid be sampled at edge t. COMPARE occupies edges t+1 … t+NUM_TEMPLATES, and rank_valid is high for exactly the cycle after edge t+NUM_TEMPLATES+1.
- With the defaults, rank_valid follows the final score by 14 cycles.
- All NUM_TEMPLATES valid bits in the same cycle in IDLE: go directly to COMPARE (no COLLECT cycle).
- Timeout and the final score_valid in the same cycle: the final score is latched, and the timeout is not flagged.
- rst mid-operation: abandon COLLECT or COMPARE, do not pulse rank_valid, and return all outputs to their reset values.

## Structure
- Shared package card_pkg holds:
  - rank_t enum (RANK_A … RANK_K, 4 bits);
  - localparams CORNER_WIDTH = 28, RANK_HEIGHT = 40, RANK_SIZE = 1120, SCORE_WIDTH = 11, NUM_RANKS = 13.
- One natural sub-module, argmin_scan: a sequential compare unit with start, candidate score/valid/index inputs, best index/score outputs and a done pulse. The top level owns the FSM, score register file, seen bits, timeout counter and overrun flag.

## Test plan
- Scores i*50+100 for i = 0..12, all in the same cycle → rank_valid 14 cycles later; rank_out 0, rank_score 100, no_match 0.
- Staggered valids, index 7 = 35 and all others 900, last valid at cycle 20 → rank_out 7, rank_score 35, no_match 0, pulse 14 cycles after cycle 20.
- Tie: indices 3 and 9 both 50, others 700 → rank_out 3.
- Best score 401 (others higher) → rank_out at the 401 slot, no_match 1, timeout 0.
- Only 12 matchers report (index 12 never) → after TIMEOUT_CYCLES, rank_valid with timeout 1 and no_match 1, winner drawn from the 12 seen; a score_valid injected during COMPARE sets overrun, which stays 1 until rst.
- rst asserted mid-COMPARE → no rank_valid pulse; outputs return to reset values; a subsequent full set of scores classifies correctly.

Source files
------------

// File: rtl/card_pkg.sv
// card_pkg: shared definitions for the card-recognition slice.
//   - Geometry of the rank corner window and the resulting score width.
//   - rank_t: template index to card rank mapping (0 = A ... 12 = K).
//   - cls_state_t: rank_classifier controller states.
//   - Default classification threshold and timeout budget.
package card_pkg;

  localparam int CORNER_WIDTH    = 28;
  localparam int RANK_HEIGHT     = 40;
  localparam int RANK_SIZE       = CORNER_WIDTH * RANK_HEIGHT;  // 1120 pixels
  localparam int SCORE_WIDTH     = $clog2(RANK_SIZE);           // 11 bits
  localparam int NUM_RANKS       = 13;
  localparam int MATCH_THRESHOLD = 400;
  localparam int TIMEOUT_CYCLES  = 4096;

  typedef enum logic [3:0] {
    RANK_A, RANK_2, RANK_3, RANK_4, RANK_5, RANK_6, RANK_7,
    RANK_8, RANK_9, RANK_10, RANK_J, RANK_Q, RANK_K
  } rank_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_COMPARE,
    ST_REPORT
  } cls_state_t;

endpackage

// File: rtl/rank_classifier_argmin_scan.sv
// argmin_scan: sequential minimum finder, one candidate per cycle.
//   clk, rst          : clock, synchronous active-high reset
//   i_start           : (re)initialise running best to all-ones / index 0
//   i_cand_en         : a candidate is presented this cycle
//   i_cand_valid      : candidate slot holds a real score
//   i_cand_score      : candidate score (unsigned)
//   i_cand_index      : candidate index
//   i_cand_last       : this is the final candidate of the scan
//   o_best_index      : index of the lowest score seen so far
//   o_best_score      : lowest score seen so far
//   o_done            : one-cycle pulse after the final candidate is absorbed
module argmin_scan #(
  parameter int NUM_TEMPLATES = 13,
  parameter int SCORE_WIDTH   = 11,
  localparam int IDX_W        = $clog2(NUM_TEMPLATES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_cand_en,
  input  logic                   i_cand_valid,
  input  logic [SCORE_WIDTH-1:0] i_cand_score,
  input  logic [IDX_W-1:0]       i_cand_index,
  input  logic                   i_cand_last,
  output logic [IDX_W-1:0]       o_best_index,
  output logic [SCORE_WIDTH-1:0] o_best_score,
  output logic                   o_done
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_best_index <= '0;
      o_best_score <= '1;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        o_best_index <= '0;
        o_best_score <= '1;
      end else if (i_cand_en) begin
        // Strictly-lower replacement keeps the lowest index on ties.
        if (i_cand_valid && (i_cand_score < o_best_score)) begin
          o_best_index <= i_cand_index;
          o_best_score <= i_cand_score;
        end
        o_done <= i_cand_last;
      end
    end
  end

endmodule

// File: rtl/rank_classifier.sv
// rank_classifier: gathers one mismatch score per rank template, then picks
// the lowest score and reports its rank with a one-cycle valid pulse.
//   clk, rst     : clock, synchronous active-high reset
//   score_in     : flattened scores, matcher i at [i*SCORE_WIDTH +: SCORE_WIDTH]
//   score_valid  : per-matcher one-cycle "score final" strobe
//   rank_out     : winning template index
//   rank_score   : mismatch count of the winner
//   rank_valid   : one-cycle pulse qualifying the four result outputs
//   no_match     : winner above threshold, or result forced by timeout
//   timeout      : result forced because not every matcher reported in time
//   overrun      : sticky; a score arrived while comparing/reporting
//   busy         : high whenever the controller is not idle
module rank_classifier
  import card_pkg::*;
#(
  parameter int NUM_TEMPLATES   = NUM_RANKS,
  parameter int SCORE_WIDTH     = card_pkg::SCORE_WIDTH,
  parameter int MATCH_THRESHOLD = card_pkg::MATCH_THRESHOLD,
  parameter int TIMEOUT_CYCLES  = card_pkg::TIMEOUT_CYCLES,
  localparam int IDX_W          = $clog2(NUM_TEMPLATES)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_TEMPLATES*SCORE_WIDTH-1:0] score_in,
  input  logic [NUM_TEMPLATES-1:0]             score_valid,
  output logic [IDX_W-1:0]                     rank_out,
  output logic [SCORE_WIDTH-1:0]               rank_score,
  output logic                                 rank_valid,
  output logic                                 no_match,
  output logic                                 timeout,
  output logic                                 overrun,
  output logic                                 busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_TEMPLATES - 1);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SCORE_WIDTH-1:0] THRESH   = SCORE_WIDTH'(MATCH_THRESHOLD);

  cls_state_t               r_state;
  logic [SCORE_WIDTH-1:0]   r_scores [NUM_TEMPLATES];
  logic [NUM_TEMPLATES-1:0] r_seen;
  logic [CNT_W-1:0]         r_count;
  logic                     r_timeout_flag;
  logic [IDX_W-1:0]         r_scan_idx;

  logic                     w_accept;
  logic [NUM_TEMPLATES-1:0] w_seen_next;
  logic                     w_all_seen;
  logic [IDX_W-1:0]         w_best_index;
  logic [SCORE_WIDTH-1:0]   w_best_score;
  logic                     w_scan_done;

  // Scores are only taken while gathering; anything later is an overrun.
  assign w_accept    = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign w_seen_next = r_seen | score_valid;
  assign w_all_seen  = &w_seen_next;
  assign busy        = (r_state != ST_IDLE);

  // NOTE: the score file has no reset; the seen bits alone say which slots
  // hold meaningful data, so clearing the storage would add nothing.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NUM_TEMPLATES; i++) begin
        if (score_valid[i]) r_scores[i] <= score_in[i*SCORE_WIDTH +: SCORE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_seen         <= '0;
      r_count        <= '0;
      r_timeout_flag <= 1'b0;
      r_scan_idx     <= '0;
      rank_out       <= '0;
      rank_score     <= '0;
      rank_valid     <= 1'b0;
      no_match       <= 1'b0;
      timeout        <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      rank_valid <= 1'b0;
      if (!w_accept && (|score_valid)) overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_scan_idx <= '0;
          if (|score_valid) begin
            r_seen         <= w_seen_next;
            r_count        <= '0;
            r_timeout_flag <= 1'b0;
            r_state        <= w_all_seen ? ST_COMPARE : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          r_scan_idx <= '0;
          r_seen     <= w_seen_next;
          // A completing score wins over a simultaneous timeout.
          if (w_all_seen) begin
            r_state <= ST_COMPARE;
          end else if (r_count == CNT_LAST) begin
            r_timeout_flag <= 1'b1;
            r_state        <= ST_COMPARE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_COMPARE: begin
          if (r_scan_idx == LAST_IDX) r_state <= ST_REPORT;
          else                        r_scan_idx <= r_scan_idx + 1'b1;
        end
        ST_REPORT: begin
          if (w_scan_done) begin
            rank_out       <= w_best_index;
            rank_score     <= w_best_score;
            no_match       <= r_timeout_flag || (w_best_score > THRESH);
            timeout        <= r_timeout_flag;
            rank_valid     <= 1'b1;
            r_seen         <= '0;
            r_count        <= '0;
            r_timeout_flag <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  argmin_scan #(
    .NUM_TEMPLATES(NUM_TEMPLATES),
    .SCORE_WIDTH  (SCORE_WIDTH)
  ) u_scan (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_accept),
    .i_cand_en    (r_state == ST_COMPARE),
    .i_cand_valid (r_seen[r_scan_idx]),
    .i_cand_score (r_scores[r_scan_idx]),
    .i_cand_index (r_scan_idx),
    .i_cand_last  (r_scan_idx == LAST_IDX),
    .o_best_index (w_best_index),
    .o_best_score (w_best_score),
    .o_done       (w_scan_done)
  );

endmodule

// File: tb/tb_rank_classifier.sv
// tb_rank_classifier: directed scoreboard bench for rank_classifier.
// The stimulus process pushes hand-computed results; a negedge monitor pops
// and compares them whenever rank_valid pulses.
module tb_rank_classifier;

  localparam int NT = 13;
  localparam int SW = 11;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NT*SW-1:0]   score_in = '0;
  logic [NT-1:0]      score_valid = '0;
  logic [3:0]         rank_out;
  logic [SW-1:0]      rank_score;
  logic               rank_valid;
  logic               no_match;
  logic               timeout;
  logic               overrun;
  logic               busy;

  rank_classifier dut (
    .clk        (clk),
    .rst        (rst),
    .score_in   (score_in),
    .score_valid(score_valid),
    .rank_out   (rank_out),
    .rank_score (rank_score),
    .rank_valid (rank_valid),
    .no_match   (no_match),
    .timeout    (timeout),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int rank;
    int score;
    int nm;
    int to;
    int cyc;   // expected pulse cycle, -1 when not checked
  } exp_t;

  exp_t       sb [$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [SW-1:0] vec [NT];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_result(input int r, input int s, input int nm, input int to, input int c);
    exp_t e;
    e.rank = r; e.score = s; e.nm = nm; e.to = to; e.cyc = c;
    sb.push_back(e);
  endtask

  // Called #1 after a posedge; the strobe is sampled at the next edge and
  // the returned t is that edge's number.
  task automatic drive(input logic [NT-1:0] mask, output int t);
    for (int i = 0; i < NT; i++) score_in[i*SW +: SW] = vec[i];
    score_valid = mask;
    @(posedge clk); #1;
    t = cyc;
    score_valid = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Monitor: compare every reported result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rank_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", int'(rank_valid), 0);
        end else begin
          e = sb.pop_front();
          check("rank_out",   int'(rank_out),   e.rank);
          check("rank_score", int'(rank_score), e.score);
          check("no_match",   int'(no_match),   e.nm);
          check("timeout",    int'(timeout),    e.to);
          if (e.cyc >= 0) check("latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int t, f;

    // Reset state.
    wait_cycles(3);
    rst = 1'b0;
    check("rst_rank_out",   int'(rank_out),   0);
    check("rst_rank_score", int'(rank_score), 0);
    check("rst_rank_valid", int'(rank_valid), 0);
    check("rst_no_match",   int'(no_match),   0);
    check("rst_timeout",    int'(timeout),    0);
    check("rst_overrun",    int'(overrun),    0);
    check("rst_busy",       int'(busy),       0);
    wait_cycles(2);

    // 1: all scores at once, i*50+100 -> rank 0 / 100.
    for (int i = 0; i < NT; i++) vec[i] = SW'(i*50 + 100);
    drive('1, t);
    expect_result(0, 100, 0, 0, t + 14);
    wait_drain(40);
    wait_cycles(3);

    // 2: staggered, index 7 first reports 500 then is overwritten with 35.
    for (int i = 0; i < NT; i++) vec[i] = 11'd900;
    vec[7] = 11'd500;
    drive(13'h000F, t);
    wait_cycles(2);
    drive(13'h00B0, t);
    wait_cycles(3);
    drive(13'h0F40, t);
    wait_cycles(4);
    check("busy_collect", int'(busy), 1);
    vec[7] = 11'd35;
    drive(13'h1080, t);
    expect_result(7, 35, 0, 0, t + 14);
    wait_drain(40);
    wait_cycles(2);

    // 3: tie between 3 and 9 at 50 -> lowest index wins.
    for (int i = 0; i < NT; i++) vec[i] = 11'd700;
    vec[3] = 11'd50; vec[9] = 11'd50;
    drive(13'h1E00, t);
    drive(13'h01FF, t);
    expect_result(3, 50, 0, 0, t + 14);
    wait_drain(40);

    // 4: best 401 is one above threshold -> no_match.
    for (int i = 0; i < NT; i++) vec[i] = SW'(450 + i);
    vec[5] = 11'd401;
    drive('1, t);
    expect_result(5, 401, 1, 0, t + 14);
    wait_drain(40);

    // 5: best exactly at threshold -> match.
    for (int i = 0; i < NT; i++) vec[i] = 11'd1000;
    vec[11] = 11'd400;
    drive('1, t);
    expect_result(11, 400, 0, 0, t + 14);
    wait_drain(40);

    // 6: index 12 never reports -> timeout; inject a score during COMPARE.
    for (int i = 0; i < NT; i++) vec[i] = 11'd300;
    vec[4] = 11'd120;
    drive(13'h0FFF, f);
    expect_result(4, 120, 1, 1, f + 4096 + 14);
    wait_cycles(4099);
    check("overrun_before", int'(overrun), 0);
    vec[12] = 11'd0;
    drive(13'h1000, t);
    check("overrun_set", int'(overrun), 1);
    wait_drain(60);
    check("overrun_sticky", int'(overrun), 1);
    wait_cycles(3);

    // 7: final score lands on the timeout cycle -> latched, no timeout.
    for (int i = 0; i < NT; i++) vec[i] = 11'd800;
    vec[12] = 11'd10;
    drive(13'h0FFF, f);
    wait_cycles(4095);
    drive(13'h1000, t);
    check("final_on_timeout_edge", t, f + 4096);
    expect_result(12, 10, 0, 0, t + 14);
    wait_drain(40);
    check("overrun_still_sticky", int'(overrun), 1);

    // 8: reset in the middle of COMPARE -> no pulse, outputs back to reset.
    for (int i = 0; i < NT; i++) vec[i] = 11'd77;
    drive('1, t);
    wait_cycles(5);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check("mid_rst_rank_out",   int'(rank_out),   0);
    check("mid_rst_rank_score", int'(rank_score), 0);
    check("mid_rst_no_match",   int'(no_match),   0);
    check("mid_rst_overrun",    int'(overrun),    0);
    check("mid_rst_busy",       int'(busy),       0);
    wait_cycles(20);

    // 9: fresh full set after reset, 600 - 20*i -> index 12 / 360.
    for (int i = 0; i < NT; i++) vec[i] = SW'(600 - 20*i);
    drive('1, t);
    expect_result(12, 360, 0, 0, t + 14);
    wait_drain(40);
    wait_cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
